nsc8_control_unit: RTL and testbench
====================================

Name: nsc8_control_unit

Overview:
- Multi-cycle control sequencer for the NSC-8 8-bit CPU.
- Steps through fetch and execute T-states and drives the load and output-enable strobes of the PC, MAR, RAM, IR, accumulator, B register, ALU and output register, all of which share the single 8-bit bus.
- Keeps the zero and carry flags, evaluates conditional jumps, and implements HLT.

Parameters:
- X, 8, data/bus width; instruction = opcode[X-1:X-4], operand[X-5:0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  1 = sequencer advances; 0 = freezes at the next FETCH0.
- instr_in  input  X  IR contents; valid from the cycle after ir_load.
- alu_zero  input  1  ALU result == 0.
- alu_carry  input  1  ALU carry/borrow out.
- pc_out_en, mar_load, mem_out_en, ir_load, pc_inc  output  1 each  fetch strobes.
- ir_out_en  output  1  IR drives the zero-extended operand onto the bus.
- pc_load  output  1  PC loads from the bus.
- load_a  output  1  accumulator loads from the bus.
- load_immediate_a  output  1  accumulator loads the immediate.
- acc_output_enable  output  1  accumulator drives the bus.
- load_b  output  1  B register loads from the bus.
- alu_op  output  2  00 ADD, 01 SUB, others reserved (drive 00).
- alu_out_en  output  1  ALU drives the bus.
- mem_write  output  1  RAM write from the bus.
- out_load  output  1  output register loads from the bus.
- zero_flag, carry_flag  output  1 each  registered flags.
- halted  output  1  1 while in HALT.

Behaviour:
- States: FETCH0, FETCH1, EXEC0, EXEC1, EXEC2, HALT (binary encoded).
- Strobes are decoded combinationally from the registered state and instr_in[X-1:X-4]. While rst=1, every strobe is forced to 0.
- Reset: state=FETCH0, zero_flag=0, carry_flag=0, halted=0.
- Reset asserted mid-instruction aborts it; the next state is FETCH0.
- FETCH0:
  - run=1: pc_out_en, mar_load; go to FETCH1.
  - run=0: no strobes; stay in FETCH0.
  - run is sampled only in FETCH0; an instruction in progress always completes.
- FETCH1: mem_out_en, ir_load, pc_inc; go to EXEC0.
- Opcode actions (per state; the last listed state returns to FETCH0):
  - 0 NOP: E0 none.
  - 1 LDA: E0 ir_out_en+mar_load; E1 mem_out_en+load_a.
  - 2 LDI: E0 load_immediate_a.
  - 3 ADD: E0 ir_out_en+mar_load; E1 mem_out_en+load_b; E2 alu_out_en+load_a, alu_op=00, flags latch.
  - 4 SUB: as ADD, with alu_op=01.
  - 5 STA: E0 ir_out_en+mar_load; E1 acc_output_enable+mem_write.
  - 6 JMP: E0 ir_out_en+pc_load.
  - 7 JZ: E0 ir_out_en+pc_load only if zero_flag=1, else no strobes.
  - 8 JC: as JZ, using carry_flag.
  - 9 OUT: E0 acc_output_enable+out_load.
  - F HLT: E0 none; go to HALT.
  - Undefined opcodes (A–E) behave as NOP.
- Flag latch: zero_flag and carry_flag are updated from alu_zero and alu_carry at the end of ADD/SUB EXEC2 only; no other instruction changes them.
- Instruction cycle counts:
  - NOP, LDI, JMP, JZ, JC, OUT, HLT: 3 cycles.
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
- HALT:
  - No strobes, halted=1.
  - Only rst exits HALT; run is ignored.
- Bus invariant: at most one of pc_out_en, mem_out_en, ir_out_en, acc_output_enable, alu_out_en is 1 in any cycle.
- Write/load exclusivity: mem_write never coincides with mem_out_en, and load_a never coincides with load_immediate_a.

Test Plan:
- Reset and gating: rst=1 for 2 cycles → all strobes 0, flags 0. Release with run=0 → stays in FETCH0 with no strobes. Set run=1 → pc_out_en+mar_load on the next cycle.
- LDI then OUT: instr_in=0x25 then 0x90 → load_immediate_a exactly once in EXEC0 of cycle 3; acc_output_enable+out_load in cycle 6; total 6 cycles.
- ADD flags:
  - instr_in=0x3A with alu_zero=1, alu_carry=1 during EXEC2 → ir_out_en+mar_load, then mem_out_en+load_b, then alu_out_en+load_a with alu_op=00; zero_flag=1, carry_flag=1 after 5 cycles.
  - SUB (0x4A) with alu_zero=0, alu_carry=0 → both flags clear.
- Conditional jump:
  - zero_flag=0, JZ 0x73 → no pc_load, 3 cycles.
  - After an ADD setting zero_flag=1, JZ 0x73 → pc_load+ir_out_en in EXEC0.
  - JC checked likewise against carry_flag.
- HLT and reset mid-operation:
  - 0xF0 → halted=1 from cycle 4 and stays there 20 cycles with run toggling.
  - rst asserted during ADD EXEC1 → next state FETCH0, halted=0, flags cleared.
- Invariant check over a random opcode stream (including A–E) → bus invariant and write/load exclusivity never violated; A–E take 3 cycles.

Source files
------------

// File: rtl/nsc8_control_unit.sv
// nsc8_control_unit: multi-cycle fetch/execute sequencer driving the NSC-8 bus strobes and flags
module nsc8_control_unit #(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [X-1:0] instr_in,
  input  logic         alu_zero,
  input  logic         alu_carry,
  output logic         pc_out_en,
  output logic         mar_load,
  output logic         mem_out_en,
  output logic         ir_load,
  output logic         pc_inc,
  output logic         ir_out_en,
  output logic         pc_load,
  output logic         load_a,
  output logic         load_immediate_a,
  output logic         acc_output_enable,
  output logic         load_b,
  output logic [1:0]   alu_op,
  output logic         alu_out_en,
  output logic         mem_write,
  output logic         out_load,
  output logic         zero_flag,
  output logic         carry_flag,
  output logic         halted
);
  localparam logic [2:0] FETCH0 = 3'd0;
  localparam logic [2:0] FETCH1 = 3'd1;
  localparam logic [2:0] EXEC0  = 3'd2;
  localparam logic [2:0] EXEC1  = 3'd3;
  localparam logic [2:0] EXEC2  = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  logic [2:0] state, state_nxt;
  logic [3:0] op;
  logic f0, f1, e0, e1, e2, mem_ref, arith, jump, unused_operand;
  assign op = instr_in[X-1:X-4];
  assign unused_operand = ^instr_in[X-5:0];
  // State qualifiers fold in !rst so every strobe drops while reset is held
  assign f0 = !rst && state == FETCH0 && run;
  assign f1 = !rst && state == FETCH1;
  assign e0 = !rst && state == EXEC0;
  assign e1 = !rst && state == EXEC1;
  assign e2 = !rst && state == EXEC2;
  assign arith   = op == 4'h3 || op == 4'h4;
  assign mem_ref = op == 4'h1 || op == 4'h5 || arith;
  assign jump    = op == 4'h6 || (op == 4'h7 && zero_flag) || (op == 4'h8 && carry_flag);
  assign pc_out_en         = f0;
  assign mar_load          = f0 || (e0 && mem_ref);
  assign mem_out_en        = f1 || (e1 && op != 4'h5);
  assign ir_load           = f1;
  assign pc_inc            = f1;
  assign ir_out_en         = e0 && (mem_ref || jump);
  assign pc_load           = e0 && jump;
  assign load_a            = (e1 && op == 4'h1) || (e2 && arith);
  assign load_immediate_a  = e0 && op == 4'h2;
  assign acc_output_enable = (e1 && op == 4'h5) || (e0 && op == 4'h9);
  assign load_b            = e1 && arith;
  assign alu_out_en        = e2 && arith;
  assign alu_op            = (e2 && op == 4'h4) ? 2'b01 : 2'b00;
  assign mem_write         = e1 && op == 4'h5;
  assign out_load          = e0 && op == 4'h9;
  assign halted            = state == HALT;
  always_comb begin
    state_nxt = state == FETCH0 ? (run ? FETCH1 : FETCH0)
              : state == FETCH1 ? EXEC0
              : state == EXEC0  ? (op == 4'hF ? HALT : mem_ref ? EXEC1 : FETCH0)
              : state == EXEC1  ? (arith ? EXEC2 : FETCH0)
              : state == HALT   ? HALT
              : FETCH0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (e2 && arith) begin
        zero_flag  <= alu_zero;
        carry_flag <= alu_carry;
      end
    end
  end
endmodule

// File: tb/tb_nsc8_control_unit.sv
// tb_nsc8_control_unit: random instruction stream checked against per-opcode micro-op lists
module tb_nsc8_control_unit;
  logic clk = 0, rst = 1, run = 0, alu_zero = 0, alu_carry = 0;
  logic [7:0] instr_in = 8'h00;
  logic pc_out_en, mar_load, mem_out_en, ir_load, pc_inc, ir_out_en, pc_load, load_a;
  logic load_immediate_a, acc_output_enable, load_b, alu_out_en, mem_write, out_load;
  logic zero_flag, carry_flag, halted;
  logic [1:0] alu_op;
  int n_cmp = 0, n_bad = 0;
  bit mzf = 0, mcf = 0;
  logic [15:0] exp_q[$];
  localparam logic [15:0] PO = 16'h8000, MAR = 16'h4000, MO = 16'h2000, IRL = 16'h1000;
  localparam logic [15:0] INC = 16'h0800, IRO = 16'h0400, PCL = 16'h0200, LA = 16'h0100;
  localparam logic [15:0] LI = 16'h0080, AO = 16'h0040, LB = 16'h0020, ALO = 16'h0010;
  localparam logic [15:0] MW = 16'h0008, OL = 16'h0004, SUBOP = 16'h0001;
  wire [15:0] strobes = {pc_out_en, mar_load, mem_out_en, ir_load, pc_inc, ir_out_en, pc_load,
                         load_a, load_immediate_a, acc_output_enable, load_b, alu_out_en,
                         mem_write, out_load, alu_op};

  nsc8_control_unit #(.X(8)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .pc_out_en(pc_out_en), .mar_load(mar_load), .mem_out_en(mem_out_en), .ir_load(ir_load),
    .pc_inc(pc_inc), .ir_out_en(ir_out_en), .pc_load(pc_load), .load_a(load_a),
    .load_immediate_a(load_immediate_a), .acc_output_enable(acc_output_enable), .load_b(load_b),
    .alu_op(alu_op), .alu_out_en(alu_out_en), .mem_write(mem_write), .out_load(out_load),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [15:0] exp, input bit hlt, input bit chk_h);
    @(negedge clk);
    chk(tag, {16'h0, strobes}, {16'h0, exp});
    if (chk_h) chk({tag, "_halted"}, {31'h0, halted}, {31'h0, hlt});
    @(posedge clk);
    #1;
  endtask

  // Micro-op list of one instruction, one entry per cycle
  task automatic build(input logic [3:0] op);
    exp_q = '{PO | MAR, MO | IRL | INC};
    case (op)
      4'h1: begin exp_q.push_back(IRO | MAR); exp_q.push_back(MO | LA); end
      4'h2: exp_q.push_back(LI);
      4'h3, 4'h4: begin
        exp_q.push_back(IRO | MAR);
        exp_q.push_back(MO | LB);
        exp_q.push_back(ALO | LA | (op == 4'h4 ? SUBOP : 16'h0));
      end
      4'h5: begin exp_q.push_back(IRO | MAR); exp_q.push_back(AO | MW); end
      4'h6: exp_q.push_back(IRO | PCL);
      4'h7: exp_q.push_back(mzf ? (IRO | PCL) : 16'h0);
      4'h8: exp_q.push_back(mcf ? (IRO | PCL) : 16'h0);
      4'h9: exp_q.push_back(AO | OL);
      default: exp_q.push_back(16'h0);
    endcase
  endtask

  task automatic do_instr(input logic [7:0] ins, input bit az, input bit ac);
    instr_in = ins;
    alu_zero = az;
    alu_carry = ac;
    run = 1;
    build(ins[7:4]);
    foreach (exp_q[i]) begin
      tick($sformatf("op%h_t%0d", ins[7:4], i), exp_q[i], 0, 1);
      run = 1'($urandom_range(0, 1));
    end
    if (ins[7:4] == 4'h3 || ins[7:4] == 4'h4) begin
      mzf = az;
      mcf = ac;
    end
    chk($sformatf("zf_after_%h", ins), {31'h0, zero_flag}, {31'h0, mzf});
    chk($sformatf("cf_after_%h", ins), {31'h0, carry_flag}, {31'h0, mcf});
  endtask

  task automatic idle(input int n);
    run = 0;
    repeat (n) tick("idle", 16'h0, 0, 1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst = 1;
    run = 1;
    repeat (2) tick("reset", 16'h0, 0, 0);
    chk("reset_zf", {31'h0, zero_flag}, 32'h0);
    chk("reset_cf", {31'h0, carry_flag}, 32'h0);
    chk("reset_halted", {31'h0, halted}, 32'h0);
    rst = 0;
    idle(3);
    do_instr(8'h25, 0, 0);
    do_instr(8'h90, 1, 1);
    do_instr(8'h73, 1, 1);
    do_instr(8'h3A, 1, 1);
    do_instr(8'h73, 0, 0);
    do_instr(8'h83, 0, 0);
    do_instr(8'h4A, 0, 0);
    do_instr(8'h73, 1, 1);
    do_instr(8'h83, 1, 1);
    do_instr(8'h3A, 0, 1);
    do_instr(8'h83, 0, 0);
    do_instr(8'h73, 0, 0);
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      do_instr({4'($urandom_range(0, 14)), 4'($urandom)}, 1'($urandom), 1'($urandom));
    end
    for (int k = 10; k <= 14; k++) do_instr({4'(k), 4'h5}, 1, 1);
    do_instr(8'h3A, 1, 1);
    instr_in = 8'h3A;
    run = 1;
    tick("abort_f0", PO | MAR, 0, 1);
    tick("abort_f1", MO | IRL | INC, 0, 1);
    tick("abort_e0", IRO | MAR, 0, 1);
    rst = 1;
    tick("abort_rst", 16'h0, 0, 0);
    rst = 0;
    mzf = 0;
    mcf = 0;
    chk("abort_zf", {31'h0, zero_flag}, 32'h0);
    chk("abort_cf", {31'h0, carry_flag}, 32'h0);
    chk("abort_halted", {31'h0, halted}, 32'h0);
    do_instr(8'h25, 0, 0);
    do_instr(8'hF0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      run = 1'($urandom_range(0, 1));
      instr_in = 8'($urandom);
      tick("halt", 16'h0, 1, 1);
    end
    rst = 1;
    tick("halt_rst", 16'h0, 0, 0);
    rst = 0;
    chk("post_halt", {31'h0, halted}, 32'h0);
    do_instr(8'h25, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bus and write/load exclusivity invariants, sampled mid-cycle
  always @(negedge clk) begin
    if ((32'(pc_out_en) + 32'(mem_out_en) + 32'(ir_out_en) + 32'(acc_output_enable) + 32'(alu_out_en)) > 1) begin
      n_bad++;
      $display("FAIL bus_invariant: strobes %h", strobes);
    end
    if ((mem_write && mem_out_en) || (load_a && load_immediate_a)) begin
      n_bad++;
      $display("FAIL exclusivity: strobes %h", strobes);
    end
  end
endmodule
